// File: rtl/uart_receiver.sv
// uart_receiver
// Serial-to-parallel UART receive stage for 8N1 frames (LSB first, idle high).
// RxD is brought into the clock domain by a two-flop synchroniser. Each bit is
// sampled at mid-period, and the completed byte is held in a one-entry output
// register.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   RxD            serial line, asynchronous to clock, idle high
//   data[7:0]      received byte, stable while data_valid = 1
//   data_valid     byte available, held until accepted
//   data_ready     consumer accepts the byte on an edge where data_valid is also high
//   busy           high whenever the receiver is not idle
//   framing_error  one-cycle pulse: the stop bit was sampled low
//   overrun        one-cycle pulse: a completed byte was dropped because the
//                  output register was still full
//
// Handshake: a byte transfers on every rising edge where data_valid and
// data_ready are both high. data_valid stays high, and data stays stable, until
// that happens. If a new byte completes on the same edge that the old byte is
// accepted, the new byte replaces the old one and data_valid stays high.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       framing_error,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             framing_error_q, framing_error_d;
    logic             overrun_q, overrun_d;

    // Strobes raised by the next-state logic on the stop-sample cycle.
    logic             frame_done;
    logic             stop_bad;
    logic             rx_s;

    assign rx_s = sync2_q;

    // State register and datapath flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            data_q          <= data_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    // Next-state and bit-timing logic.
    always_comb begin
        sync1_d    = RxD;
        sync2_d    = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        stop_bad   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                // A half-period wait lands the remaining samples mid-bit. A line
                // that is high again here was only a glitch.
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line returns high. Otherwise a break
                // condition would look like a stream of start bits.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register and delivery rule.
    always_comb begin
        data_d          = data_q;
        data_valid_d    = data_valid_q;
        framing_error_d = stop_bad;
        overrun_d       = 1'b0;
        if (frame_done) begin
            if (!data_valid_q || data_ready) begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    // Output logic.
    always_comb begin
        busy          = (state_q != IDLE);
        data          = data_q;
        data_valid    = data_valid_q;
        framing_error = framing_error_q;
        overrun       = overrun_q;
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver with CLKS_PER_BIT = 16.
// The frame drivers schedule the expected outcome of each frame in a queue:
// the completion edge, and either a byte or a framing error. They also set the
// expected busy window, working from the documented latencies. A reference
// process replays the delivery rule on those events and checks every output
// on every falling edge.
module tb_uart_receiver;

  localparam int C   = 16;
  localparam int BIG = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       framing_error;
  logic       overrun;

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .clock         (clk),
    .reset         (rst_n),
    .RxD           (rxd),
    .data          (data),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .busy          (busy),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         at;
    bit         fe;
    logic [7:0] b;
  } ev_t;
  ev_t ev_q[$];

  int busy_from = 0;
  int busy_to   = 0;
  int pending_stop = 0;

  // Reference model state (values after the most recent rising edge).
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_fe    = 1'b0;
  logic       exp_ovr   = 1'b0;

  // Observed statistics used by the directed checks.
  int         valid_cycles = 0;
  int         fe_count     = 0;
  int         ovr_count    = 0;
  logic [7:0] last_valid_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + compare ----------------
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_fe    = 1'b0;
        exp_ovr   = 1'b0;
        ev_q.delete();
        busy_from = 0;
        busy_to   = 0;
      end else begin
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
        while (ev_q.size() > 0 && ev_q[0].at < cyc) void'(ev_q.pop_front());
        if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
          e = ev_q.pop_front();
          if (e.fe) begin
            exp_fe = 1'b1;
          end else if (!exp_valid || data_ready) begin
            exp_data  = e.b;
            exp_valid = 1'b1;
          end else begin
            exp_ovr = 1'b1;
          end
        end else if (exp_valid && data_ready) begin
          exp_valid = 1'b0;
        end
      end
      @(negedge clk);
      check("data", 32'(data), 32'(exp_data));
      check("data_valid", 32'(data_valid), 32'(exp_valid));
      check("framing_error", 32'(framing_error), 32'(exp_fe));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      check("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc < busy_to)));
      if (data_valid) begin
        valid_cycles++;
        last_valid_data = data;
      end
      if (framing_error) fe_count++;
      if (overrun) ovr_count++;
    end
  end

  // ---------------- driver tasks ----------------
  // Every driver action happens 1 time unit after a falling edge.
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Drives one frame. The first edge that sees RxD low is f. The line reaches
  // rx_s two edges later, so busy rises at f+2. The start bit is sampled at
  // f+2+C/2, and the stop bit 9 bit periods after that.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    int   f;
    ev_t  e;
    rxd          = 1'b0;
    f            = cyc + 1;
    busy_from    = f + 2;
    pending_stop = f + 2 + C / 2 + 9 * C;
    busy_to      = stop_bit ? pending_stop : BIG;
    e.at = pending_stop;
    e.fe = !stop_bit;
    e.b  = b;
    ev_q.push_back(e);
    hold(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold(C);
    end
    rxd = stop_bit;
    hold(C);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int v0, f0, o0, bcnt, f, guard;
    rst_n      = 1'b0;
    rxd        = 1'b1;
    data_ready = 1'b0;
    hold(3);
    check("reset_data", 32'(data), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    hold(5);

    // 1: single byte, consumer always ready.
    data_ready = 1'b1;
    v0 = valid_cycles; f0 = fe_count; o0 = ovr_count;
    send_frame(8'hA5, 1'b1);
    hold(4);
    check("t1_byte", 32'(last_valid_data), 32'hA5);
    check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("t1_no_fe", 32'(fe_count - f0), 32'd0);
    check("t1_no_ovr", 32'(ovr_count - o0), 32'd0);
    check("t1_idle", 32'(busy), 32'h0);

    // 2: 4-cycle glitch on the line.
    v0 = valid_cycles;
    bcnt = 0;
    rxd = 1'b0;
    f = cyc + 1;
    busy_from = f + 2;
    busy_to   = f + 2 + C / 2;
    for (int i = 0; i < 4; i++) begin
      hold(1);
      if (busy) bcnt++;
    end
    rxd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hold(1);
      if (busy) bcnt++;
    end
    check("t2_busy_bounded", 32'((bcnt >= 1) && (bcnt <= 10)), 32'd1);
    check("t2_no_valid", 32'(valid_cycles - v0), 32'd0);

    // 3: stop bit low, then the line held low (break), then a good frame.
    v0 = valid_cycles; f0 = fe_count;
    send_frame(8'h3C, 1'b0);
    hold(50);
    check("t3_busy_in_break", 32'(busy), 32'h1);
    rxd = 1'b1;
    busy_to = cyc + 3;
    hold(C);
    check("t3_fe_pulses", 32'(fe_count - f0), 32'd1);
    check("t3_no_valid", 32'(valid_cycles - v0), 32'd0);
    send_frame(8'h81, 1'b1);
    hold(4);
    check("t3_next_byte", 32'(last_valid_data), 32'h81);

    // 4: two bytes with the consumer stalled, which drops the second.
    data_ready = 1'b0;
    o0 = ovr_count;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold(4);
    check("t4_data_kept", 32'(data), 32'h11);
    check("t4_valid_held", 32'(data_valid), 32'h1);
    check("t4_ovr_pulses", 32'(ovr_count - o0), 32'd1);
    data_ready = 1'b1;
    hold(2);
    check("t4_valid_cleared", 32'(data_valid), 32'h0);
    data_ready = 1'b0;
    hold(4);

    // 5: accept the old byte on exactly the completion edge of the new one.
    o0 = ovr_count;
    send_frame(8'h55, 1'b1);
    hold(2);
    check("t5_first", 32'(data), 32'h55);
    fork
      send_frame(8'h66, 1'b1);
      begin
        hold(2);
        guard = 0;
        while (cyc != pending_stop - 1 && guard < 4000) begin
          hold(1);
          guard++;
        end
        check("t5_sync_in_budget", 32'(guard < 4000), 32'd1);
        data_ready = 1'b1;
        hold(1);
        data_ready = 1'b0;
      end
    join
    hold(3);
    check("t5_data_new", 32'(data), 32'h66);
    check("t5_valid_kept", 32'(data_valid), 32'h1);
    check("t5_no_ovr", 32'(ovr_count - o0), 32'd0);
    data_ready = 1'b1;
    hold(3);

    // 6: reset in the middle of data bit 4 of 0xF0, then receive 0x0F.
    f0 = fe_count; o0 = ovr_count;
    rxd = 1'b0;
    f = cyc + 1;
    busy_from = f + 2;
    busy_to   = BIG;
    hold(C);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0] ? 1'b0 : 1'b0;
      hold(C);
    end
    rxd = 1'b1;
    hold(C / 2);
    check("t6_busy_before_reset", 32'(busy), 32'h1);
    rst_n = 1'b0;
    hold(1);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_valid", 32'(data_valid), 32'h0);
    check("t6_rst_data", 32'(data), 32'h00);
    hold(2);
    rxd   = 1'b1;
    rst_n = 1'b1;
    hold(C);
    v0 = valid_cycles;
    send_frame(8'h0F, 1'b1);
    hold(4);
    check("t6_byte", 32'(last_valid_data), 32'h0F);
    check("t6_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("t6_no_fe", 32'(fe_count - f0), 32'd0);
    check("t6_no_ovr", 32'(ovr_count - o0), 32'd0);

    hold(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; consumes the TxD line produced by the transmit stage (8N1, LSB first, idle high).
- Synchronises the asynchronous RxD input and samples each bit at mid-period.
- Presents each received byte through a one-entry output register with a valid/ready handshake.
- Flags stop-bit (framing) errors and overruns.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit period (100 MHz / 9600 baud); legal range 4 and up.
- CNT_W, $clog2(CLKS_PER_BIT), baud counter width (derived; not overridden).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- RxD  input  1  serial line, asynchronous to clock, idle high.
- data  output  8  received byte; stable while data_valid = 1.
- data_valid  output  1  byte available; held until accepted.
- data_ready  input  1  consumer accepts the byte when data_valid & data_ready are both high on a clock edge.
- busy  output  1  high in every state except IDLE.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because the output register was still full.

Behaviour:
- Reset (reset = 0, asynchronous):
  - 2-FF synchroniser resets to 1; state resets to IDLE; counters and shift register reset to 0.
  - data = 0x00; data_valid, busy, framing_error and overrun reset to 0.
  - A reset mid-frame discards the partial frame; the receiver restarts in IDLE after reset deasserts.
- All sampling uses rx_s, the output of the 2-FF synchroniser (2-cycle latency from RxD).
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - When rx_s = 0: go to START, baud counter = 0.
- START:
  - Count to CLKS_PER_BIT/2 - 1 (integer divide), then sample.
  - rx_s = 0: go to DATA, counter = 0, bit index = 0.
  - rx_s = 1: treat as a glitch; return to IDLE with no outputs.
- DATA:
  - Count to CLKS_PER_BIT - 1, sample rx_s, shift it into the MSB of the shift register (right shift), counter = 0.
  - After bit index 7 is sampled, go to STOP. Bit index is 3 bits and does not wrap within a frame.
- STOP:
  - Count to CLKS_PER_BIT - 1, then sample.
  - rx_s = 1: frame complete; go to IDLE and run the delivery rule.
  - rx_s = 0: pulse framing_error for one cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a break condition from being re-detected as a start bit.
- Delivery rule, evaluated on the frame-complete cycle; the registered outputs update on the next edge:
  - data_valid = 0: data <= byte, data_valid <= 1.
  - data_valid = 1 and data_ready = 1: the old byte is accepted and the new byte is loaded; data_valid stays 1.
  - data_valid = 1 and data_ready = 0: the new byte is dropped, overrun pulses for one cycle, and the old byte and valid are retained.
- Handshake: when data_valid & data_ready with no completion in the same cycle, data_valid <= 0 on the next edge and data holds its value.
- Latency: data_valid rises 1 cycle after the stop sample. The stop sample occurs 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after RxD falls.
- Arithmetic: the baud counter is CNT_W bits, compared with ==, and cleared on every sample. No counter free-runs outside START, DATA and STOP.
- busy = (state != IDLE), driven combinationally from the state register.

Test Plan (CLKS_PER_BIT = 16 unless stated):
- Send 0xA5 (8N1, 16 cycles/bit), data_ready = 1 on first valid -> data = 0xA5, data_valid high exactly 1 cycle, framing_error = overrun = 0, busy low after the stop sample.
- Pull RxD low for 4 cycles, then high -> returns to IDLE from START; data_valid never asserts; busy high for at most 10 cycles.
- Send 0x3C with stop bit = 0, then hold RxD low 50 cycles -> one framing_error pulse, no data_valid, busy stays high (WAIT_HIGH) until RxD returns high, then the next frame 0x81 is received correctly.
- Send 0x11 then 0x22 back-to-back with data_ready = 0 -> data = 0x11 retained, data_valid held, one overrun pulse at the 0x22 completion; raising data_ready then clears data_valid.
- Send 0x55 then 0x66 with data_ready asserted exactly in the 0x66 completion cycle -> 0x55 accepted, data = 0x66, data_valid stays 1, no overrun.
- Assert reset in the middle of data bit 4 of 0xF0, release it, then send 0x0F -> all outputs 0 during reset, then data = 0x0F with no spurious valid or error.
